// File: rtl/rot_sched_pkg.sv
// Shared types and constants for the rotate scheduler and its arbiter.
package rot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic SRC_A     = 1'b0;
    localparam logic SRC_B     = 1'b1;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/rot_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last winner.
module rr_arb2
    import rot_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == SRC_B) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_B;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/rot_sched.sv
// Scheduler that sequences load/rotate strobes of the shared byte datapath for two requesters.
module rot_sched
    import rot_sched_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic              dir_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [CNT_W-1:0]  cnt_b,
    input  logic              dir_b,
    output logic              ack_b,
    output logic              sel,
    output logic              r_l,
    output logic              load,
    output logic              rot,
    input  logic [DATA_W-1:0] dp_q,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              result_src,
    output logic              busy
);

    state_t           state;
    logic             src;
    logic [CNT_W-1:0] cnt_r;
    logic             dir_r;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       grant;
    logic             accept;

    assign accept = rst && (state == IDLE) && (grant != 2'b00);
    assign ack_a  = accept && grant[0];
    assign ack_b  = accept && grant[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req_b, req_a}),
        .update (accept),
        .grant  (grant)
    );

    // Strobes are set on the edge entering their state so they are registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            src          <= SRC_A;
            cnt_r        <= '0;
            dir_r        <= DIR_RIGHT;
            remaining    <= '0;
            sel          <= SRC_A;
            r_l          <= DIR_RIGHT;
            load         <= 1'b0;
            rot          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_src   <= SRC_A;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        src   <= grant[1];
                        cnt_r <= grant[1] ? cnt_b : cnt_a;
                        dir_r <= grant[1] ? dir_b : dir_a;
                        sel   <= grant[1];
                        load  <= 1'b1;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    load <= 1'b0;
                    if (cnt_r == '0) begin
                        state <= DONE;
                    end else begin
                        remaining <= cnt_r;
                        rot       <= 1'b1;
                        r_l       <= (dir_r == DIR_LEFT);
                        state     <= ROTATE;
                    end
                end
                ROTATE: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        rot   <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    result       <= dp_q;
                    result_src   <= src;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
